// File: rtl/bitserial_pkg.sv
// Shared types and constants for the bit-serial RV32 sequencer.
package bitserial_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OPK_LSB  = 2'd0,
        OPK_BR   = 2'd1,
        OPK_SET  = 2'd2,
        OPK_RSVD = 2'd3
    } op_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Compare kinds walk the operands from the MSB down.
    function automatic logic is_msb_first(input op_kind_e kind);
        return (kind == OPK_BR) || (kind == OPK_SET);
    endfunction

endpackage

// File: rtl/bitserial_idx_ctr.sv
// Loadable up/down bit-index counter with an explicit terminal flag.
// The counter is exactly IDX_W bits wide and never relies on wrap-around.
module bitserial_idx_ctr #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             step,
    input  logic             down,
    output logic [IDX_W-1:0] idx,
    output logic             term
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XLEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Index register: load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (load) begin
            idx <= load_val;
        end else if (step) begin
            idx <= down ? (idx - IDX_ONE) : (idx + IDX_ONE);
        end
    end

    // Terminal slice depends on walk direction.
    always_comb begin
        term = down ? (idx == '0) : (idx == IDX_LAST);
    end

endmodule

// File: rtl/bitserial_seq.sv
// Sequencer for the 1-bit-slice RV32 datapath: accepts one decoded op,
// steps the bit index across XLEN slices and owns the inter-slice carry
// and compare-chain registers.
// Optional macro BSEQ_PERF_CNT_EN adds perf_busy / perf_ops counters.
module bitserial_seq
    import bitserial_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned IDX_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_kind,
    input  logic             op_sub,
    input  logic             op_signed,
    input  logic             op_rd_we,
    input  logic             op_pc_we,
    output logic [IDX_W-1:0] bit_idx,
    output logic             bit_en,
    output logic             alu_cin,
    input  logic             alu_cout,
    output logic             pc_cin,
    output logic             pc_adder_4,
    input  logic             pc_cout,
    output logic             cmp_eq_in,
    output logic             cmp_lt_in,
    input  logic             cmp_eq_out,
    input  logic             cmp_lt_out,
    output logic             cmp_msb_flip,
    output logic             rd_we_bit,
    output logic             pc_we_bit,
    output logic             wb_sel_cmp,
    output logic             cmp_res_bit,
    output logic             done,
    output logic             done_eq,
    output logic             done_lt,
    output logic             done_err
`ifdef BSEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_busy,
    output logic [31:0]      perf_ops
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XLEN - 1);
    localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

    seq_state_e       state;
    op_kind_e         kind;
    logic             signed_r;
    logic             rd_we_r;
    logic             pc_we_r;
    logic             alu_carry;
    logic             pc_carry;
    logic             eq_r;
    logic             lt_r;

    logic             ctr_load;
    logic [IDX_W-1:0] ctr_load_val;
    logic             ctr_step;
    logic             ctr_down;
    logic [IDX_W-1:0] idx;
    logic             term;

    logic             msb_first;
    logic             run_lsb;
    logic             run_msb;
    logic             is_rsvd;

    bitserial_idx_ctr #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W)
    ) u_idx_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .step     (ctr_step),
        .down     (ctr_down),
        .idx      (idx),
        .term     (term)
    );

    // Index counter control: seed on accept / WB entry, step until terminal.
    always_comb begin
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        ctr_step     = 1'b0;
        ctr_down     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    ctr_load     = 1'b1;
                    ctr_load_val = is_msb_first(op_kind_e'(op_kind)) ? IDX_LAST : '0;
                end
            end
            ST_RUN: begin
                ctr_down = msb_first;
                if (term) begin
                    if (kind == OPK_SET) begin
                        ctr_load     = 1'b1;
                        ctr_load_val = '0;
                    end
                end else begin
                    ctr_step = 1'b1;
                end
            end
            ST_WB: begin
                if (!term) begin
                    ctr_step = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Main FSM plus the carry and compare-chain state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            kind      <= OPK_LSB;
            signed_r  <= 1'b0;
            rd_we_r   <= 1'b0;
            pc_we_r   <= 1'b0;
            alu_carry <= 1'b0;
            pc_carry  <= 1'b0;
            eq_r      <= 1'b1;
            lt_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        kind      <= op_kind_e'(op_kind);
                        signed_r  <= op_signed;
                        rd_we_r   <= op_rd_we;
                        pc_we_r   <= op_pc_we;
                        alu_carry <= op_sub;
                        pc_carry  <= 1'b0;
                        eq_r      <= 1'b1;
                        lt_r      <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (msb_first) begin
                        eq_r <= cmp_eq_out;
                        lt_r <= cmp_lt_out;
                    end else begin
                        alu_carry <= alu_cout;
                        pc_carry  <= pc_cout;
                    end
                    if (term) begin
                        state <= (kind == OPK_SET) ? ST_WB : ST_DONE;
                    end
                end
                ST_WB: begin
                    if (term) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        msb_first    = is_msb_first(kind);
        run_lsb      = (state == ST_RUN) && !msb_first;
        run_msb      = (state == ST_RUN) && msb_first;
        is_rsvd      = (kind == OPK_RSVD);

        op_ready     = (state == ST_IDLE);
        bit_idx      = idx;
        bit_en       = (state == ST_RUN) || (state == ST_WB);
        alu_cin      = alu_carry;
        pc_cin       = pc_carry;
        cmp_eq_in    = eq_r;
        cmp_lt_in    = lt_r;
        pc_adder_4   = run_lsb && (idx == IDX_TWO);
        cmp_msb_flip = run_msb && signed_r && (idx == IDX_LAST);
        rd_we_bit    = (run_lsb && !is_rsvd && rd_we_r) || ((state == ST_WB) && rd_we_r);
        pc_we_bit    = run_lsb && !is_rsvd && pc_we_r;
        wb_sel_cmp   = (state == ST_WB);
        cmp_res_bit  = (state == ST_WB) && (idx == '0) && lt_r;
        done         = (state == ST_DONE);
        done_eq      = (state == ST_DONE) && eq_r;
        done_lt      = (state == ST_DONE) && lt_r;
        done_err     = (state == ST_DONE) && is_rsvd;
    end

`ifdef BSEQ_PERF_CNT_EN
    // Busy-cycle and completed-op counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy <= '0;
            perf_ops  <= '0;
        end else begin
            if ((state == ST_RUN) || (state == ST_WB)) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (state == ST_DONE) begin
                perf_ops <= perf_ops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/bitserial_seq.md
Name: bitserial_seq

Overview:
- Sequencer for the 1-bit-slice RV32 datapath (ALU, PC adder, comparator, rd writeback mux).
- Accepts one decoded op per handshake and steps a bit index across XLEN cycles, LSB-first or MSB-first.
- Owns the inter-cycle state registers: ALU carry, PC-adder carry, comparator eq/lt chain.
- Drives per-bit rd/PC write enables, then signals completion to the issuing decode stage.

Parameters:
- XLEN, 32, datapath width in bits, number of bit cycles per pass.
- IDX_W, $clog2(XLEN), bit index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  decoded op offered
- op_ready  out  1  sequencer can accept (IDLE only)
- op_kind  in  2  0=LSB pass (add/logic/shift/jal), 1=CMP branch, 2=CMP set (slt*), 3=reserved
- op_sub  in  1  ALU carry-in seed (1 for sub/inverted rs2)
- op_signed  in  1  signed compare
- op_rd_we  in  1  op writes rd
- op_pc_we  in  1  op writes PC
- bit_idx  out  IDX_W  current bit slice
- bit_en  out  1  a bit slice is live this cycle
- alu_cin  out  1  registered ALU carry into current slice
- alu_cout  in  1  ALU carry out of current slice
- pc_cin  out  1  registered PC carry
- pc_adder_4  out  1  constant-4 bit for current slice
- pc_cout  in  1  PC carry out
- cmp_eq_in, cmp_lt_in  out  1 each  registered chain state
- cmp_eq_out, cmp_lt_out  in  1 each  chain result of current slice
- cmp_msb_flip  out  1  datapath inverts both compare operand bits this slice
- rd_we_bit  out  1  write rd[bit_idx]
- pc_we_bit  out  1  write pc[bit_idx]
- wb_sel_cmp  out  1  rd mux selects cmp_res_bit
- cmp_res_bit  out  1  slt result bit for current slice
- done  out  1  one-cycle completion pulse
- done_eq, done_lt  out  1 each  final compare flags, valid with done
- done_err  out  1  with done: op_kind was 3

Behaviour:
- FSM states: IDLE, RUN, WB, DONE. Reset: state=IDLE, all outputs 0, op_ready=1 in the following cycles, bit_idx=0, carries=0, eq=1, lt=0.
- Accept when op_valid&&op_ready (IDLE). Latch kind/flags. Seed alu_carry=op_sub, pc_carry=0, eq=1, lt=0.
- Accept also sets bit_idx: XLEN-1 for kinds 1/2, else 0. Next state RUN.
- RUN: bit_en=1.
  - Kind 0/3: LSB-first, each cycle alu_carry<=alu_cout, pc_carry<=pc_cout.
  - pc_adder_4 = (bit_idx==2).
  - rd_we_bit=op_rd_we&&kind!=3; pc_we_bit=op_pc_we&&kind!=3.
  - Kind 1/2: MSB-first, eq<=cmp_eq_out, lt<=cmp_lt_out.
  - cmp_msb_flip=op_signed on the bit_idx==XLEN-1 cycle only.
  - rd_we_bit=0; pc_we_bit=0.
- RUN end: after the last slice (idx XLEN-1 LSB-first, or 0 MSB-first):
  - Kind 2 goes to WB with bit_idx=0.
  - All other kinds go to DONE.
- WB: XLEN cycles LSB-first, bit_en=1, rd_we_bit=op_rd_we, wb_sel_cmp=1, cmp_res_bit=(bit_idx==0)?lt:0. Then DONE.
- DONE: done=1 for one cycle, done_eq/done_lt/done_err held from final chain state, op_ready=0. Next state IDLE.
- Latency (accept at cycle T to done cycle):
  - Kind 0/1/3: T+XLEN+1.
  - Kind 2: T+2*XLEN+1.
  - Back-to-back issue: the next accept is possible the cycle after done.
- bit_idx never wraps within a pass; counter is exact-width and the terminal compare is explicit.
- rst in any state aborts the op: no further write enables from the next cycle, no done pulse.
- op_valid while busy is ignored (op_ready=0). Input op fields are sampled only at accept.

Optional Feature:
- Macro BSEQ_PERF_CNT_EN.
  - When defined: adds outputs perf_busy [31:0] (counts cycles in RUN/WB) and perf_ops [31:0] (counts done pulses). Both clear on rst and wrap at 2^32.
  - When undefined: no ports, no counters.

Decomposition:
- Package bitserial_pkg:
  - op_kind_e enum (OPK_LSB, OPK_BR, OPK_SET, OPK_RSVD).
  - seq_state_e enum.
  - XLEN default constant.
- One sub-module, bitserial_idx_ctr: loadable up/down IDX_W counter with direction input and terminal flag.

Test Plan:
- Reset then kind0, op_sub=1, op_rd_we=1 -> bit_idx 0..31 over 32 cycles, alu_cin=1 in the first slice, rd_we_bit high for all 32 slices, done at T+33.
- Kind1 unsigned, datapath models rs1=5, rs2=7 -> bit_idx 31..0, no write enables, done_lt=1, done_eq=0.
- Kind2 signed, rs1=-1, rs2=1 -> cmp_msb_flip only at idx31, WB pass writes bit0=1 and bits1..31=0, done at T+65.
- Kind0 with op_pc_we=1, op_rd_we=0 -> pc_adder_4 high only at idx2, pc_we_bit high for 32 slices, rd_we_bit always 0.
- rst asserted at RUN idx 10 -> next cycle IDLE, op_ready=1, no done, no write enables; new op completes normally.
- Kind3 -> no write enables, done with done_err=1; op_valid held during busy is not accepted until after done.
